// File: rtl/br_wr_arb_pkg.sv
// br_wr_arb_pkg: shared widths, register-bank constants and requester encoding for the writeback arbiter
package br_wr_arb_pkg;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int REG_X0 = 0;
  typedef enum logic {REQ0 = 1'b0, REQ1 = 1'b1} req_e;
endpackage

// File: rtl/br_wr_arb_pick.sv
// br_wr_arb_pick: combinational grant selection from the two valids and the priority pointer
module br_wr_arb_pick
  import br_wr_arb_pkg::*;
(
  input  logic v0,
  input  logic v1,
  input  req_e prio,
  output logic g0,
  output logic g1
);
  always_comb begin
    g0 = v0 & (~v1 | (prio == REQ0));
    g1 = v1 & (~v0 | (prio == REQ1));
  end
endmodule

// File: rtl/br_wr_arb.sv
// br_wr_arb: two-requester register-bank write arbiter with a registered write stage
// Define BR_WR_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module br_wr_arb
  import br_wr_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              r0_valid,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_data,
  output logic              r0_ready,
  input  logic              r1_valid,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_data,
  output logic              r1_ready,
  output logic              we,
  output logic [ADDR_W-1:0] a3,
  output logic [DATA_W-1:0] wd,
  output logic [ADDR_W-1:0] busy_addr
);
  logic              g0, g1, xfer;
  req_e              prio;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] a3_q, a3_d, sel_addr;
  logic [DATA_W-1:0] wd_q, wd_d, sel_data;

  br_wr_arb_pick u_pick (
    .v0  (r0_valid),
    .v1  (r1_valid),
    .prio(prio),
    .g0  (g0),
    .g1  (g1)
  );

  // x0 transfers are accepted but never reach the bank
  always_comb begin
    r0_ready = ~rst & ~hold & g0;
    r1_ready = ~rst & ~hold & g1;
    xfer     = r0_ready | r1_ready;
    sel_addr = r1_ready ? r1_addr : r0_addr;
    sel_data = r1_ready ? r1_data : r0_data;
    we_d     = xfer & (sel_addr != ADDR_W'(REG_X0));
    a3_d     = we_d ? sel_addr : a3_q;
    wd_d     = we_d ? sel_data : wd_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q <= 1'b0;
      a3_q <= '0;
      wd_q <= '0;
    end else begin
      we_q <= we_d;
      a3_q <= a3_d;
      wd_q <= wd_d;
    end
  end

`ifdef BR_WR_ARB_RR_EN
  req_e prio_q, prio_d;
  always_comb prio_d = r0_ready ? REQ1 : r1_ready ? REQ0 : prio_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prio_q <= REQ0;
    else     prio_q <= prio_d;
  end
  always_comb prio = prio_q;
`else
  always_comb prio = REQ0;
`endif

  assign we        = we_q;
  assign a3        = a3_q;
  assign wd        = wd_q;
  assign busy_addr = we_q ? a3_q : '0;
endmodule

// File: doc/br_wr_arb.md
BR_WR_ARB -- requirements
Module: br_wr_arb

Interface
REQ-001 Parameter ADDR_W, default 5, register address width; SHALL match the register bank's a1/a2/a3 width.
REQ-002 Parameter DATA_W, default 32, write-data width; SHALL match the register bank's wd width.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 hold  input  1  freezes arbitration; no request is accepted while high.
REQ-006 r0_valid  input  1  requester 0 (ALU writeback) has a write pending.
REQ-007 r0_addr  input  ADDR_W  destination register for requester 0.
REQ-008 r0_data  input  DATA_W  write data for requester 0.
REQ-009 r0_ready  output  1  requester 0 write accepted this cycle.
REQ-010 r1_valid, r1_addr, r1_data, r1_ready  SHALL be the same as REQ-006..009, for requester 1 (load writeback).
REQ-011 we  output  1  register bank write enable, registered.
REQ-012 a3  output  ADDR_W  register bank write address, registered.
REQ-013 wd  output  DATA_W  register bank write data, registered.
REQ-014 busy_addr  output  ADDR_W  copy of a3, qualified by we, for hazard checks.

Function
REQ-015 Handshake: a request SHALL transfer only in a cycle where rX_valid=1 and rX_ready=1.
REQ-016 Ready rule: rX_ready SHALL be combinational, high only when hold=0, rX_valid=1 and X is the granted requester; at most one ready SHALL be high per cycle.
REQ-017 Latency: a transfer in cycle N SHALL drive we/a3/wd in cycle N+1 for exactly one cycle.
REQ-018 No-transfer cycle: in any cycle with no transfer, we SHALL be 0 in the next cycle, and a3/wd SHALL hold their last values.
REQ-019 x0 writes: a transfer with addr=0 SHALL be accepted (ready=1), SHALL leave we=0 in cycle N+1, and SHALL still update the round-robin pointer.
REQ-020 Single requester valid: that requester SHALL be granted in the same cycle, with no bubble.
REQ-021 Both requesters valid: the requester selected by the priority pointer `prio` SHALL be granted; the loser SHALL keep valid asserted and SHALL be granted in the next cycle if hold=0.
REQ-022 Pointer update: after any transfer by requester X, prio SHALL point to the other requester.
REQ-023 Same address from both requesters simultaneously: both writes SHALL occur on consecutive cycles, in grant order; the later value SHALL persist in the bank.
REQ-024 hold=1 SHALL force both ready signals to 0 and leave prio unchanged; a write already registered SHALL still complete.
REQ-025 Throughput: the block SHALL sustain one write per cycle while any requester is valid and hold=0.

Reset
REQ-026 While rst=1, the block SHALL force we=0, a3=0, wd=0, busy_addr=0 and prio=requester 0, without waiting for a clock edge.
REQ-027 A write registered but not yet presented SHALL be discarded on reset.
REQ-028 Ready signals SHALL be 0 while rst=1.

Configuration
REQ-029 Macro BR_WR_ARB_RR_EN: when defined, arbitration SHALL be round-robin per REQ-021/022.
REQ-030 When BR_WR_ARB_RR_EN is undefined, arbitration SHALL be fixed priority, requester 0 over requester 1; the prio register SHALL be absent.

Structure
REQ-031 ADDR_W/DATA_W defaults and the requester-index encoding (REQ0=0, REQ1=1) SHALL live in the shared rv32i package, alongside the register bank constants.
REQ-032 One sub-module, br_wr_arb_pick (combinational grant selection from valids and prio), is natural; the registered write stage SHALL stay in the top module.

Verification
REQ-033 Reset, then r0_valid=1, r0_addr=5, r0_data=0xDEADBEEF -> r0_ready=1 the same cycle; next cycle we=1, a3=5, wd=0xDEADBEEF; the cycle after, we=0.
REQ-034 (RR build) Both valid for 4 cycles, r0_addr=1, r1_addr=2 -> grants in order r0, r1, r0, r1; a3 sequence 1, 2, 1, 2.
REQ-035 Both valid, both addr=7, r0_data=0x11, r1_data=0x22 -> consecutive writes 0x11 then 0x22.
REQ-036 r1_valid=1, r1_addr=0, r1_data=0xFFFFFFFF -> r1_ready=1; next cycle we=0; prio then points to r0.
REQ-037 hold=1 for 3 cycles with r0 valid -> r0_ready=0 throughout and we=0 after the pending write drains; hold=0 -> grant resumes in the same cycle.
REQ-038 Assert rst asynchronously mid-stream, between clock edges -> we and a3 go to 0 immediately; the first grant after release goes to r0.
